// File: rtl/ltc2333_pkg.sv
// Shared LTC2333 word layout, span type and the span sign rule.
package ltc2333_pkg;
    localparam int RES_MSB  = 23;
    localparam int RES_LSB  = 6;
    localparam int CH_MSB   = 5;
    localparam int CH_LSB   = 3;
    localparam int SPAN_MSB = 2;
    localparam int RES_W    = RES_MSB - RES_LSB + 1;

    typedef logic [SPAN_MSB:0] span_t;

    typedef struct packed {
        logic [RES_W-1:0]     res;
        logic [CH_MSB:CH_LSB] ch;
        span_t                span;
    } adc_word_t;

    function automatic logic is_bipolar(span_t s);
        return (s == 3'd2) || (s == 3'd3) || (s == 3'd6) || (s == 3'd7);
    endfunction
endpackage

// File: rtl/ltc2333_accum_bank.sv
// Eight per-channel {sum, count, span} accumulators; reports when a write completes an average.
module ltc2333_accum_bank
    import ltc2333_pkg::*;
#(
    parameter int AVG_LOG2_MAX = 8,
    parameter int SUM_W        = 18 + AVG_LOG2_MAX
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             clear_all,
    input  logic             wr_en,
    input  logic [2:0]       ch,
    input  span_t            span,
    input  logic [SUM_W-1:0] sample,
    input  logic [3:0]       avg_log2,
    output logic             out_done,
    output logic [SUM_W-1:0] out_sum
);
    localparam int NCNT_W = AVG_LOG2_MAX + 1;

    logic [7:0][SUM_W-1:0]  sum_q;
    logic [7:0][NCNT_W-1:0] cnt_q;
    span_t [7:0]            span_q;

    logic              restart;
    logic [NCNT_W-1:0] new_cnt;
    logic [NCNT_W-1:0] target;

    // A span change (or a simultaneous clear) makes this sample the first of a new average.
    always_comb begin
        restart  = clear_all || (span != span_q[ch]);
        out_sum  = (restart ? '0 : sum_q[ch]) + sample;
        new_cnt  = (restart ? '0 : cnt_q[ch]) + 1'b1;
        target   = NCNT_W'(1) << avg_log2;
        out_done = wr_en && (new_cnt == target);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sum_q  <= '0;
            cnt_q  <= '0;
            span_q <= '0;
        end else begin
            if (clear_all) begin
                sum_q <= '0;
                cnt_q <= '0;
            end
            if (wr_en) begin
                span_q[ch] <= span;
                sum_q[ch]  <= out_done ? '0 : out_sum;
                cnt_q[ch]  <= out_done ? '0 : new_cnt;
            end
        end
    end
endmodule

// File: rtl/ltc2333_sample_averager.sv
// Pops LTC2333 words from the deserializer FIFO, averages 2^avg_log2 samples per channel
// and emits one AXI-Stream beat per completed channel sum.
module ltc2333_sample_averager
    import ltc2333_pkg::*;
#(
    parameter int AVG_LOG2_MAX = 8,
    parameter int SUM_W        = 18 + AVG_LOG2_MAX,
    parameter int LAST_CH      = 7,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             FIFO_notEmpty,
    output logic             FIFO_rden,
    input  logic [31:0]      FIFO_dout,
    input  logic             enable,
    input  logic [3:0]       avg_log2,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [CNT_W-1:0] drop_count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_PROC = 2'd2;

    logic [1:0]       state;
    logic [31:0]      word_q;
    logic [3:0]       avg_q;
    logic [3:0]       avg_clamped;
    adc_word_t        word;
    logic             malformed;
    logic             wr_en;
    logic             clear_all;
    logic [SUM_W-1:0] sample;
    logic             out_done;
    logic [SUM_W-1:0] out_sum;

    assign avg_clamped = (avg_log2 > 4'(AVG_LOG2_MAX)) ? 4'(AVG_LOG2_MAX) : avg_log2;
    assign clear_all   = !enable || (avg_clamped != avg_q);

    assign word      = adc_word_t'(word_q[RES_MSB:0]);
    assign malformed = (|word_q[31:RES_MSB+1]) || (word.span == 3'd0);
    assign wr_en     = (state == S_PROC) && !malformed;
    assign sample    = is_bipolar(word.span) ? {{(SUM_W-RES_W){word.res[RES_W-1]}}, word.res}
                                             : {{(SUM_W-RES_W){1'b0}}, word.res};

    // No pop while a beat is pending, so the output register is never overwritten.
    assign FIFO_rden = aresetn && (state == S_IDLE) && enable && FIFO_notEmpty && !m_axis_tvalid;

    ltc2333_accum_bank #(
        .AVG_LOG2_MAX(AVG_LOG2_MAX),
        .SUM_W       (SUM_W)
    ) u_bank (
        .clk      (clk),
        .aresetn  (aresetn),
        .clear_all(clear_all),
        .wr_en    (wr_en),
        .ch       (word.ch),
        .span     (word.span),
        .sample   (sample),
        .avg_log2 (avg_clamped),
        .out_done (out_done),
        .out_sum  (out_sum)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= S_IDLE;
            word_q        <= '0;
            avg_q         <= '0;
            drop_count    <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            avg_q <= avg_clamped;
            case (state)
                S_IDLE: if (FIFO_rden) state <= S_WAIT;
                S_WAIT: begin
                    word_q <= FIFO_dout;
                    state  <= S_PROC;
                end
                S_PROC: begin
                    if (malformed && (drop_count != '1)) drop_count <= drop_count + 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
            if (wr_en && out_done) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= 32'({word.ch, word.span, out_sum});
                m_axis_tlast  <= (word.ch == 3'(LAST_CH));
            end
        end
    end
endmodule

// File: tb/tb_ltc2333_sample_averager.sv
// Randomized bench for ltc2333_sample_averager with a queue-based FIFO and a per-channel averaging model.
module tb_ltc2333_sample_averager;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             aresetn = 1'b1;
    logic             fifo_not_empty;
    logic             fifo_rden;
    logic [31:0]      fifo_dout = '0;
    logic             enable = 1'b0;
    logic [3:0]       avg_log2 = '0;
    logic [31:0]      tdata;
    logic             tvalid;
    logic             tready = 1'b1;
    logic             tlast;
    logic [CNT_W-1:0] drop_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] fifo_q[$];
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];

    longint msum[8];
    int     mcnt[8];
    int     mspan[8];
    int     mavg = 0;
    int     exp_drops = 0;

    always #5 clk = ~clk;

    ltc2333_sample_averager #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .FIFO_notEmpty(fifo_not_empty),
        .FIFO_rden    (fifo_rden),
        .FIFO_dout    (fifo_dout),
        .enable       (enable),
        .avg_log2     (avg_log2),
        .m_axis_tdata (tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tlast (tlast),
        .drop_count   (drop_count)
    );

    assign fifo_not_empty = (fifo_q.size() != 0);

    always @(posedge clk) begin
        if (fifo_rden && fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
    end

    // Beats are recorded at the negative edge before the accepting posedge.
    always @(negedge clk) begin
        if (aresetn && tvalid && tready) got_q.push_back({tlast, tdata});
    end

    function automatic void model_clear();
        for (int c = 0; c < 8; c++) begin
            msum[c] = 0;
            mcnt[c] = 0;
        end
    endfunction

    function automatic void model_word(logic [31:0] w);
        int          ch;
        int          sp;
        longint      s;
        logic [63:0] lsum;
        logic [2:0]  ch3;
        logic [2:0]  sp3;
        ch = int'(w[5:3]);
        sp = int'(w[2:0]);
        if (w[31:24] != 0 || sp == 0) begin
            if (exp_drops < (1 << CNT_W) - 1) exp_drops++;
            return;
        end
        s = longint'(w[23:6]);
        if ((sp == 2 || sp == 3 || sp == 6 || sp == 7) && w[23]) s = s - 262144;
        if (sp != mspan[ch]) begin
            msum[ch]  = s;
            mcnt[ch]  = 1;
            mspan[ch] = sp;
        end else begin
            msum[ch] += s;
            mcnt[ch]++;
        end
        if (mcnt[ch] == (1 << mavg)) begin
            lsum = msum[ch];
            ch3  = w[5:3];
            sp3  = w[2:0];
            exp_q.push_back({(ch == 7), ch3, sp3, lsum[25:0]});
            msum[ch] = 0;
            mcnt[ch] = 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        model_word(w);
    endtask

    task automatic set_avg(input int v);
        int c;
        avg_log2 = 4'(v);
        c = (v > 8) ? 8 : v;
        if (c != mavg) begin
            mavg = c;
            model_clear();
        end
        repeat (2) tick();
    endtask

    task automatic drain();
        int n = 0;
        while ((fifo_q.size() != 0 || tvalid) && n < 2000) begin
            tick();
            n++;
        end
        repeat (6) tick();
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL drain_timeout: fifo_left=%0d tvalid=%b", fifo_q.size(), tvalid);
        end
    endtask

    function automatic logic [31:0] rand_word(input logic [2:0] ch, input logic [2:0] sp);
        logic [31:0] w;
        w = $urandom & 32'h00FF_FFC0;
        w[5:3] = ch;
        w[2:0] = sp;
        return w;
    endfunction

    task automatic test_reset();
        #2 aresetn = 1'b0;
        enable = 1'b1;
        fifo_q.push_back(32'h00FF_FFFF);
        repeat (3) tick();
        checks += 5;
        if (fifo_rden !== 1'b0) begin errors++; $display("FAIL reset_rden: got=%b exp=0", fifo_rden); end
        if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got=%b exp=0", tvalid); end
        if (tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: got=%h exp=0", tdata); end
        if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got=%b exp=0", tlast); end
        if (drop_count !== '0) begin errors++; $display("FAIL reset_drop: got=%0d exp=0", drop_count); end
        fifo_q.delete();
        aresetn = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_passthrough();
        logic [32:0] g;
        logic [32:0] e;
        set_avg(0);
        push(32'h00FF_FFFF);
        drain();
        checks++;
        if (got_q.size() == 0 || got_q[0] !== {1'b1, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL passthrough_first: got=%h exp=1ffffffff", (got_q.size() != 0) ? got_q[0] : 33'h0);
        end
        for (int i = 0; i < 10; i++) push(rand_word(3'($urandom), 3'($urandom_range(1, 7))));
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL passthrough_count: got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL passthrough_beat: got=%h exp=%h", g, e); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_avg4();
        set_avg(2);
        repeat (3) push(32'h0080_0015);
        drain();
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL avg4_early: got=%0d beats exp=0", got_q.size()); end
        push(32'h0080_0015);
        drain();
        checks += 2;
        if (got_q.size() != 1) begin errors++; $display("FAIL avg4_count: got=%0d exp=1", got_q.size()); end
        if (got_q.size() == 0 || got_q[0] !== {1'b0, 32'h5408_0000}) begin
            errors++;
            $display("FAIL avg4_beat: got=%h exp=054080000", (got_q.size() != 0) ? got_q[0] : 33'h0);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_interleave();
        logic [2:0]  sp0;
        logic [2:0]  sp1;
        logic [32:0] g;
        logic [32:0] e;
        sp0 = 3'($urandom_range(1, 7));
        sp1 = 3'($urandom_range(1, 7));
        set_avg(1);
        for (int i = 0; i < 12; i++) push(rand_word(3'(i % 2), (i % 2 == 0) ? sp0 : sp1));
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL interleave_count: got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL interleave_beat: got=%h exp=%h", g, e); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_drop();
        push(32'h0100_0047);
        push(32'h00AB_CD40);
        drain();
        checks += 3;
        if (drop_count !== CNT_W'(exp_drops)) begin
            errors++;
            $display("FAIL drop_count: got=%0d exp=%0d", drop_count, exp_drops);
        end
        if (drop_count !== CNT_W'(2)) begin errors++; $display("FAIL drop_two: got=%0d exp=2", drop_count); end
        if (got_q.size() != 0) begin errors++; $display("FAIL drop_beat: got=%0d beats exp=0", got_q.size()); end
        for (int i = 0; i < 20; i++) push(($urandom & 32'hFFFF_FFF8) | 32'h0100_0000);
        drain();
        checks += 2;
        if (drop_count !== CNT_W'(exp_drops)) begin
            errors++;
            $display("FAIL drop_model: got=%0d exp=%0d", drop_count, exp_drops);
        end
        if (drop_count !== '1) begin errors++; $display("FAIL drop_saturate: got=%0d exp=all-ones", drop_count); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [31:0] snap;
        logic [32:0] g;
        logic [32:0] e;
        int          n = 0;
        set_avg(0);
        tready = 1'b0;
        for (int i = 0; i < 4; i++) push(rand_word(3'($urandom), 3'($urandom_range(1, 7))));
        while (!tvalid && n < 40) begin
            tick();
            n++;
        end
        snap = tdata;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (fifo_rden !== 1'b0 || tvalid !== 1'b1 || tdata !== snap) begin
                errors++;
                $display("FAIL backpressure_hold: rden=%b tvalid=%b tdata=%h exp rden=0 tvalid=1 tdata=%h",
                         fifo_rden, tvalid, tdata, snap);
            end
        end
        checks++;
        if (fifo_q.size() != 3) begin errors++; $display("FAIL backpressure_fifo: got=%0d exp=3", fifo_q.size()); end
        tready = 1'b1;
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL backpressure_count: got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL backpressure_beat: got=%h exp=%h", g, e); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_enable();
        logic [31:0] w;
        w = rand_word(3'd5, 3'd4);
        set_avg(1);
        push(rand_word(3'd5, 3'd4));
        drain();
        enable = 1'b0;
        model_clear();
        fifo_q.push_back(w);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (fifo_rden !== 1'b0) begin errors++; $display("FAIL enable_rden: got=%b exp=0", fifo_rden); end
        end
        enable = 1'b1;
        model_word(w);
        push(w);
        drain();
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL enable_beat: got=%0d beats first=%h exp=%0d beats first=%h", got_q.size(),
                     (got_q.size() != 0) ? got_q[0] : 33'h0, exp_q.size(), (exp_q.size() != 0) ? exp_q[0] : 33'h0);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_avg_change_and_reset();
        int n = 0;
        set_avg(2);
        push(rand_word(3'd3, 3'd1));
        drain();
        set_avg(1);
        push(rand_word(3'd3, 3'd1));
        push(rand_word(3'd3, 3'd1));
        drain();
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL avgchange_beat: got=%0d beats first=%h exp=%0d beats first=%h", got_q.size(),
                     (got_q.size() != 0) ? got_q[0] : 33'h0, exp_q.size(), (exp_q.size() != 0) ? exp_q[0] : 33'h0);
        end
        got_q.delete();
        exp_q.delete();

        push(rand_word(3'd3, 3'd1));
        fifo_q.push_back(rand_word(3'd3, 3'd1));
        while (fifo_q.size() > 1 && n < 40) begin tick(); n++; end
        n = 0;
        do begin @(negedge clk); n++; end while (!fifo_rden && n < 40);
        @(posedge clk);
        #1 aresetn = 1'b0;
        model_clear();
        for (int c = 0; c < 8; c++) mspan[c] = 0;
        exp_drops = 0;
        tick();
        checks += 5;
        if (fifo_rden !== 1'b0) begin errors++; $display("FAIL midreset_rden: got=%b exp=0", fifo_rden); end
        if (tvalid !== 1'b0) begin errors++; $display("FAIL midreset_tvalid: got=%b exp=0", tvalid); end
        if (tdata !== 32'h0) begin errors++; $display("FAIL midreset_tdata: got=%h exp=0", tdata); end
        if (tlast !== 1'b0) begin errors++; $display("FAIL midreset_tlast: got=%b exp=0", tlast); end
        if (drop_count !== '0) begin errors++; $display("FAIL midreset_drop: got=%0d exp=0", drop_count); end
        repeat (2) tick();
        aresetn = 1'b1;
        repeat (3) tick();
        got_q.delete();
        exp_q.delete();
        push(rand_word(3'd3, 3'd1));
        push(rand_word(3'd3, 3'd1));
        drain();
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL midreset_fresh: got=%0d beats first=%h exp=%0d beats first=%h", got_q.size(),
                     (got_q.size() != 0) ? got_q[0] : 33'h0, exp_q.size(), (exp_q.size() != 0) ? exp_q[0] : 33'h0);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        model_clear();
        for (int c = 0; c < 8; c++) mspan[c] = 0;
        test_reset();
        test_passthrough();
        test_avg4();
        test_interleave();
        test_drop();
        test_backpressure();
        test_enable();
        test_avg_change_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
